// File: rtl/rgb_pwm_ctrl.sv
// rgb_pwm_ctrl: Wishbone classic slave driving three RGB LED PWM lines.
// A prescaler divides clk by CLK_DIV+1 and clocks a shared 8-bit PWM counter.
// Each channel holds a bus-visible target duty (tgt) and a shadow duty (cur).
// Only cur drives the comparator, and cur changes only at period end, so the
// LED never sees a partial-period duty change.
// Optional feature macro: RGB_PWM_FADE_EN. When it is defined, ctrl.FADE makes
// cur step by one LSB toward tgt every FADE_PERIODS PWM periods.
// When it is undefined, ctrl.FADE reads 0 and cur always snaps to tgt.
//
// Register map (wb_adr_i):
//   0 tgt_r[7:0]   1 tgt_g[7:0]   2 tgt_b[7:0]
//   3 ctrl: bit0 EN, bit1 FADE, bit8 BUSY (read-only, any cur != tgt)
module rgb_pwm_ctrl #(
  parameter int CLK_DIV      = 47,
  parameter int FADE_PERIODS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        led_r,
  output logic        led_g,
  output logic        led_b
);

  // A CLK_DIV of 0 still needs a 1-bit prescaler so the compare stays legal.
  localparam int              PSC_W  = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);
  localparam logic [PSC_W-1:0] PSC_TC = PSC_W'(CLK_DIV);
  localparam logic [1:0]       ADR_CTRL = 2'd3;

  logic [PSC_W-1:0] r_psc;
  logic [7:0]       r_pwm_cnt;
  logic [7:0]       r_tgt [0:2];
  logic [7:0]       r_cur [0:2];
  logic             r_en;
  logic             r_ack;
  logic [31:0]      r_dat;
  logic [2:0]       r_led_p1;

  logic             w_psc_wrap;
  logic             w_period_end;
  logic             w_req;
  logic             w_wr;
  logic             w_ctrl_wr;
  logic             w_busy;
  logic             w_fade_on;
  logic [31:0]      w_rd_data;
  logic [2:0]       w_led_p0;
  logic             w_unused;

  assign w_psc_wrap   = (r_psc == PSC_TC);
  assign w_period_end = w_psc_wrap && (r_pwm_cnt == 8'hFF);

  // A new request is only accepted while no ack is outstanding, which gives
  // the one-cycle ack pulse and the two-cycle back-to-back rhythm.
  assign w_req     = wb_cyc_i && wb_stb_i && !r_ack;
  assign w_wr      = w_req && wb_we_i && wb_sel_i[0];
  assign w_ctrl_wr = w_wr && (wb_adr_i == ADR_CTRL);

  assign w_busy = (r_cur[0] != r_tgt[0]) ||
                  (r_cur[1] != r_tgt[1]) ||
                  (r_cur[2] != r_tgt[2]);

  // Prescaler: counts 0..CLK_DIV and wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_psc <= '0;
    end else if (w_psc_wrap) begin
      r_psc <= '0;
    end else begin
      r_psc <= r_psc + 1'b1;
    end
  end

  // Shared PWM counter: advances once per prescaler wrap, wraps mod 256.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pwm_cnt <= 8'd0;
    end else if (w_psc_wrap) begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end
  end

  // Bus acknowledge: one cycle after an accepted request, dropped by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ack <= 1'b0;
    end else begin
      r_ack <= w_req;
    end
  end

  // Register read mux; unused bits are zero.
  always_comb begin
    w_rd_data = '0;
    case (wb_adr_i)
      2'd0: w_rd_data[7:0] = r_tgt[0];
      2'd1: w_rd_data[7:0] = r_tgt[1];
      2'd2: w_rd_data[7:0] = r_tgt[2];
      default: begin
        w_rd_data[0] = r_en;
        w_rd_data[1] = w_fade_on;
        w_rd_data[8] = w_busy;
      end
    endcase
  end

  // Read data register: holds the addressed register only during the ack cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dat <= '0;
    end else if (w_req && !wb_we_i) begin
      r_dat <= w_rd_data;
    end else begin
      r_dat <= '0;
    end
  end

  // Target duty registers, written through byte lane 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        r_tgt[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_wr && (wb_adr_i == 2'(i))) begin
          r_tgt[i] <= wb_dat_i[7:0];
        end
      end
    end
  end

  // Output enable bit of ctrl.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_en <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_en <= wb_dat_i[0];
    end
  end

`ifdef RGB_PWM_FADE_EN
  localparam int              FC_W  = (FADE_PERIODS <= 1) ? 1 : $clog2(FADE_PERIODS);
  localparam logic [FC_W-1:0] FC_TC = FC_W'(FADE_PERIODS - 1);

  logic            r_fade;
  logic [FC_W-1:0] r_fade_cnt;
  logic            w_fade_tick;

  // One LSB toward the target, never past it.
  function automatic logic [7:0] step_toward(input logic [7:0] cur,
                                             input logic [7:0] tgt);
    logic [7:0] nxt;
    nxt = cur;
    if (cur < tgt) begin
      nxt = cur + 8'd1;
    end else if (cur > tgt) begin
      nxt = cur - 8'd1;
    end
    return nxt;
  endfunction

  assign w_fade_on   = r_fade;
  assign w_fade_tick = w_period_end && (r_fade_cnt == FC_TC);
  assign w_unused    = ^{wb_sel_i[3:1], wb_dat_i[31:8]};

  // Fade mode bit of ctrl.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fade <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_fade <= wb_dat_i[1];
    end
  end

  // Fade counter: counts period ends 0..FADE_PERIODS-1, runs whatever FADE is.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fade_cnt <= '0;
    end else if (w_period_end) begin
      if (r_fade_cnt == FC_TC) begin
        r_fade_cnt <= '0;
      end else begin
        r_fade_cnt <= r_fade_cnt + 1'b1;
      end
    end
  end

  // Shadow duties: ramp on fade ticks in fade mode, otherwise snap at period
  // end. The old target is used when a write lands on the period-end edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        r_cur[i] <= 8'd0;
      end
    end else if (w_period_end) begin
      for (int i = 0; i < 3; i++) begin
        if (!w_fade_on) begin
          r_cur[i] <= r_tgt[i];
        end else if (w_fade_tick) begin
          r_cur[i] <= step_toward(r_cur[i], r_tgt[i]);
        end
      end
    end
  end
`else
  assign w_fade_on = 1'b0;
  assign w_unused  = ^{wb_sel_i[3:1], wb_dat_i[31:8], 1'(FADE_PERIODS)};

  // Shadow duties snap to the targets at every period end.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        r_cur[i] <= 8'd0;
      end
    end else if (w_period_end) begin
      for (int i = 0; i < 3; i++) begin
        r_cur[i] <= r_tgt[i];
      end
    end
  end
`endif

  // ---- stage p0: duty compare against the shared counter ----
  always_comb begin
    w_led_p0 = '0;
    for (int i = 0; i < 3; i++) begin
      w_led_p0[i] = r_en && (r_pwm_cnt < r_cur[i]);
    end
  end

  // ---- stage p1: registered LED drive ----
  // Registered LED outputs so the pads see clean, glitch-free edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_led_p1 <= 3'b000;
    end else begin
      r_led_p1 <= w_led_p0;
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;
  assign led_r    = r_led_p1[0];
  assign led_g    = r_led_p1[1];
  assign led_b    = r_led_p1[2];

endmodule
